// File: rtl/ss_entrada_pkg.sv
// Shared types and defaults for the Booth multiplier input subsystem.
// Holds the entry FSM state encoding and the default parameter values.
package ss_entrada_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } ent_state_t;

  localparam int DEF_W    = 4;
  localparam int DEF_DEB  = 4;
  localparam int DEF_SYNC = 2;

endpackage

// File: rtl/ss_entrada_deb_antirrebote.sv
// Push-button synchroniser and debouncer.
// Ports: clk, rst (async, active-high), raw button in;
//   stable debounced level, press (rise pulse), release_p (fall pulse).
import ss_entrada_pkg::*;

module antirrebote #(
  parameter int DEB_CYCLES = DEF_DEB,
  parameter int SYNC_FF    = DEF_SYNC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press,
  output logic release_p
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_FF-1:0] sync_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               stable_q, stable_d;
  logic               prev_q;
  logic               lvl;

  assign lvl = sync_q[SYNC_FF-1];

  // The edge that completes DEB_CYCLES differing samples
  // commits the new level, so the count tops out at
  // DEB_CYCLES-1 before the update.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (lvl == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      stable_d = lvl;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_FF-2:0], raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign stable    = stable_q;
  assign press     = stable_q & ~prev_q;
  assign release_p = ~stable_q & prev_q;

endmodule

// File: rtl/ss_entrada_deb.sv
// Input stage for the Booth multiplier: syncs A/B and the button,
// captures A/B on each debounced press.
// Ports: clk, rst (async, active-high), A, B, boton, ready in;
//   valid, _A, _B, busy out.
import ss_entrada_pkg::*;

module ss_entrada_deb #(
  parameter int W          = DEF_W,
  parameter int DEB_CYCLES = DEF_DEB,
  parameter int SYNC_FF    = DEF_SYNC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         boton,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] _A,
  output logic [W-1:0] _B,
  output logic         busy
);

  logic [W-1:0] a_sync_q [SYNC_FF];
  logic [W-1:0] b_sync_q [SYNC_FF];
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         valid_q, valid_d;
  ent_state_t   state_q, state_d;
  logic         stable, press, rel;

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES),
    .SYNC_FF   (SYNC_FF)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .raw      (boton),
    .stable   (stable),
    .press    (press),
    .release_p(rel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_FF; i++) begin
        a_sync_q[i] <= '0;
        b_sync_q[i] <= '0;
      end
    end else begin
      a_sync_q[0] <= A;
      b_sync_q[0] <= B;
      for (int i = 1; i < SYNC_FF; i++) begin
        a_sync_q[i] <= a_sync_q[i-1];
        b_sync_q[i] <= b_sync_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          a_d     = a_sync_q[SYNC_FF-1];
          b_d     = b_sync_q[SYNC_FF-1];
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = stable ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (!stable || rel) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign valid = valid_q;
  assign _A    = a_q;
  assign _B    = b_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ss_entrada_deb.sv
// Scoreboard bench for ss_entrada_deb (W=4, DEB_CYCLES=4, SYNC_FF=2).
// Expected captures are queued by the stimulus; a monitor checks each one.
module tb_ss_entrada_deb;

  logic       clk = 1'b0;
  logic       rst, boton, ready;
  logic [3:0] A, B;
  logic       valid, busy;
  logic [3:0] _A, _B;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];
  logic       vprev = 1'b0;

  ss_entrada_deb #(
    .W(4), .DEB_CYCLES(4), .SYNC_FF(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .boton(boton),
    .ready(ready),
    .valid(valid),
    ._A   (_A),
    ._B   (_B),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every new valid must match the oldest queued capture.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && valid && !vprev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_capture: got %h%h expected none",
                 _A, _B);
      end else begin
        e = exp_q.pop_front();
        if ({_A, _B} !== e) begin
          n_bad++;
          $display("FAIL capture_AB: got %h%h expected %h",
                   _A, _B, e);
        end
      end
    end
    vprev = valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; boton = 1'b0; ready = 1'b0;
    A = 4'h0; B = 4'h0;
    #1;
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_A",     {4'd0, _A},    8'd0);
    chk("rst_B",     {4'd0, _B},    8'd0);
    chk("rst_busy",  {7'd0, busy},  8'd0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("idle_valid", {7'd0, valid}, 8'd0);

    // Clean press: valid after edge k+6, not before
    A = 4'h5; B = 4'hB; boton = 1'b1;
    exp_q.push_back(8'h5B);
    step(6);
    chk("lat_k5_valid", {7'd0, valid}, 8'd0);
    chk("lat_k5_busy",  {7'd0, busy},  8'd0);
    step(1);
    chk("lat_k6_valid", {7'd0, valid}, 8'd1);
    chk("lat_k6_busy",  {7'd0, busy},  8'd1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("hold_valid", {7'd0, valid}, 8'd1);
      chk("hold_AB",    {_A, _B},      8'h5B);
    end

    // Handshake with A changed during HOLD
    A = 4'hF;
    step(3);
    chk("frozen_A", {4'd0, _A}, 8'h05);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("hs_valid", {7'd0, valid}, 8'd0);
    chk("hs_busy",  {7'd0, busy},  8'd1);
    chk("hs_keep",  {_A, _B},      8'h5B);
    step(3);
    chk("wait_busy", {7'd0, busy}, 8'd1);
    boton = 1'b0;
    step(5);
    chk("rel_j4_busy", {7'd0, busy}, 8'd1);
    step(2);
    chk("rel_j6_busy", {7'd0, busy}, 8'd0);

    // Bounce: three single-cycle highs
    for (int i = 0; i < 6; i++) begin
      boton = (i % 2 == 0);
      step(1);
    end
    boton = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bounce_valid", {7'd0, valid}, 8'd0);
      chk("bounce_busy",  {7'd0, busy},  8'd0);
    end

    // Re-press during HOLD is ignored
    A = 4'h3; B = 4'h4;
    exp_q.push_back(8'h34);
    boton = 1'b1;
    step(10);
    chk("p1_valid", {7'd0, valid}, 8'd1);
    boton = 1'b0;
    step(10);
    A = 4'h9; B = 4'h1; boton = 1'b1;
    step(10);
    chk("repress_AB",    {_A, _B},      8'h34);
    chk("repress_valid", {7'd0, valid}, 8'd1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("p1_hs_valid", {7'd0, valid}, 8'd0);
    boton = 1'b0;
    step(10);
    chk("p1_idle_busy", {7'd0, busy}, 8'd0);
    A = 4'h8; B = 4'h7;
    exp_q.push_back(8'h87);
    boton = 1'b1;
    step(10);
    chk("p2_AB",    {_A, _B},      8'h87);
    chk("p2_valid", {7'd0, valid}, 8'd1);

    // Asynchronous reset while in HOLD
    #2;
    rst = 1'b1; boton = 1'b0;
    #1;
    chk("mid_rst_valid", {7'd0, valid}, 8'd0);
    chk("mid_rst_AB",    {_A, _B},      8'h00);
    chk("mid_rst_busy",  {7'd0, busy},  8'd0);
    step(1);
    rst = 1'b0;
    step(8);
    A = 4'h2; B = 4'hE;
    exp_q.push_back(8'h2E);
    ready = 1'b1; boton = 1'b1;
    step(10);
    chk("rdy_hi_valid", {7'd0, valid}, 8'd0);
    chk("rdy_hi_busy",  {7'd0, busy},  8'd1);
    chk("rdy_hi_AB",    {_A, _B},      8'h2E);
    boton = 1'b0;
    step(10);
    ready = 1'b0;
    chk("end_busy", {7'd0, busy}, 8'd0);
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
